binary2bcd_seq: RTL and testbench

Parametrised, multi-cycle binary-to-BCD converter using the iterative shift-add-3 (double-dabble) algorithm, one bit per clock. It replaces the fixed 8-bit combinational converter wherever wide values (counters, round indices, debug/display readouts) need decimal output without a deep combinational adder chain. It has valid/ready handshakes on both sides so it can sit between a producer and a display/UART formatter. It also flags values that do not fit in the configured digit count.

---
 rtl/binary2bcd_seq_pkg.sv | 31 +++
 rtl/binary2bcd_seq_digit_adj.sv | 12 +
 rtl/binary2bcd_seq.sv | 107 ++++++++++
 tb/tb_binary2bcd_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/binary2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM encoding, the add-3 adjust constants and a digit-count helper.
package binary2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Smallest DIGITS that holds every value of an unsigned width-bit input.
  function automatic int min_digits(input int width);
    longint unsigned maxv;
    longint unsigned p;
    int              d;
    maxv = (64'd1 << width) - 64'd1;
    p    = 64'd10;
    d    = 1;
    for (int i = 0; i < 19; i++) begin
      if (p <= maxv) begin
        d++;
        p = p * 64'd10;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/binary2bcd_seq_digit_adj.sv
// One double-dabble digit correction: a BCD digit of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import binary2bcd_seq_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

// File: rtl/binary2bcd_seq.sv
// Multi-cycle binary-to-BCD converter, one double-dabble iteration per clock,
// with valid/ready on both sides and a sticky flag for values beyond DIGITS.
module binary2bcd_seq
  import binary2bcd_seq_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + IN_WIDTH;
  localparam int CW = $clog2(IN_WIDTH + 1);

  state_t          r_state;
  logic [SW-1:0]   r_sr;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [BW-1:0]   r_out_bcd;
  logic            r_out_ovf;

  logic [BW-1:0]   w_bcd_adj;
  logic [SW-1:0]   w_shifted;
  logic            w_carry;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_digit (r_sr[IN_WIDTH + 4*g +: 4]),
        .o_digit (w_bcd_adj[4*g +: 4])
      );
    end
  endgenerate

  // Adjusted digits and the remaining binary bits move up together; the bit
  // leaving the top digit is a decimal carry the output cannot represent.
  assign w_shifted = {w_bcd_adj[BW-2:0], r_sr[IN_WIDTH-1:0], 1'b0};
  assign w_carry   = w_bcd_adj[BW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_bcd   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_sr       <= {{BW{1'b0}}, in_data};
            r_ovf      <= 1'b0;
            r_cnt      <= CW'(IN_WIDTH);
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_sr  <= w_shifted;
          r_ovf <= r_ovf | w_carry;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_out_bcd   <= w_shifted[SW-1 -: BW];
            r_out_ovf   <= r_ovf | w_carry;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // Result registers are left alone; out_valid alone qualifies them.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_bcd   = r_out_bcd;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_binary2bcd_seq.sv
// Randomised scoreboard bench for binary2bcd_seq: a driver pushes decimal
// reference results, a monitor pops and compares whenever a result appears.
module tb_binary2bcd_seq;
  import binary2bcd_seq_pkg::*;

  localparam int W   = 8;
  localparam int D   = 3;
  localparam int W16 = 16;
  localparam int D16 = min_digits(16);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance: 8 bits, 3 digits
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_ovf;
  logic [W-1:0]  in_data = '0;
  logic [11:0]   out_bcd;
  // overflow-capable instance: 8 bits, 2 digits
  logic          d2_in_valid = 1'b0, d2_in_ready, d2_out_valid, d2_out_ovf;
  logic [7:0]    d2_in_data = '0;
  logic [7:0]    d2_out_bcd;
  // wide instance: 16 bits, 5 digits
  logic          w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ovf;
  logic [15:0]   w_in_data = '0;
  logic [19:0]   w_out_bcd;

  binary2bcd_seq #(.IN_WIDTH(W), .DIGITS(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_ovf(out_ovf));

  binary2bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .in_data(d2_in_data), .out_valid(d2_out_valid), .out_ready(1'b1),
    .out_bcd(d2_out_bcd), .out_ovf(d2_out_ovf));

  binary2bcd_seq #(.IN_WIDTH(W16), .DIGITS(D16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_data(w_in_data), .out_valid(w_out_valid), .out_ready(1'b1),
    .out_bcd(w_out_bcd), .out_ovf(w_out_ovf));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_to(input string name, input int n, input int limit);
    checks++;
    if (n < limit) passes++;
    else $display("FAIL %s: waited %0d cycles, limit %0d", name, n, limit);
  endtask

  // Reference: decimal digits of v by repeated division, truncated to d digits.
  function automatic logic [63:0] ref_bcd(input longint unsigned v, input int d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input longint unsigned v, input int d);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return v >= p;
  endfunction

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   sent = 0;
  int   got  = 0;
  int   cyc  = 0;
  bit   bp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // backpressure: random stalls of up to 20 cycles
  initial begin
    int hold;
    hold = 0;
    forever begin
      @(negedge clk);
      if (!bp_en) out_ready = 1'b1;
      else if (hold > 0) begin
        out_ready = 1'b0;
        hold--;
      end else if ($urandom_range(0, 3) == 0) begin
        hold = $urandom_range(0, 19);
        out_ready = 1'b0;
      end else out_ready = 1'b1;
    end
  end

  // monitor
  logic        prev_v = 1'b0;
  logic        mhs;
  logic [11:0] hold_bcd = '0;
  logic        hold_ovf = 1'b0;
  exp_t        me;

  always @(posedge clk) begin
    #1;
    if (!rst_n) prev_v = 1'b0;
    else begin
      mhs = prev_v && out_ready;
      if (out_valid && !prev_v) begin
        got++;
        if (q.size() == 0) chk("unexpected_result", {51'd0, out_ovf, out_bcd}, 64'hDEAD);
        else begin
          me = q.pop_front();
          chk("bcd", out_bcd, me.bcd);
          chk("ovf", out_ovf, me.ovf);
          chk("latency", cyc - me.acc, W);
        end
        hold_bcd = out_bcd;
        hold_ovf = out_ovf;
      end else if (out_valid && prev_v) begin
        chk("stable_bcd", {out_ovf, out_bcd}, {hold_ovf, hold_bcd});
      end
      if (mhs) chk("after_handshake_ready_valid", {in_ready, out_valid}, 2'b10);
      if (out_valid || q.size() > 0) chk("in_ready_busy", in_ready, 1'b0);
      prev_v = out_valid;
    end
  end

  // called just after a negedge; returns just after a negedge
  task automatic send(input logic [W-1:0] v, input bit keep);
    int          n;
    logic [63:0] rb;
    exp_t        e;
    n = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_to("accept_wait", n, 200);
    @(posedge clk);
    #1;
    rb    = ref_bcd(v, D);
    e.bcd = rb[11:0];
    e.ovf = ref_ovf(v, D);
    e.acc = cyc;
    q.push_back(e);
    sent++;
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk_to("drain", n, 2000);
    @(negedge clk);
  endtask

  task automatic run_d2(input logic [7:0] v);
    int          n;
    logic [63:0] rb;
    n = 0;
    d2_in_valid = 1'b1;
    d2_in_data  = v;
    while (!d2_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    d2_in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!d2_out_valid && n < 50);
    rb = ref_bcd(v, 2);
    chk("d2_latency", n, 8);
    chk("d2_bcd", d2_out_bcd, rb[7:0]);
    chk("d2_ovf", d2_out_ovf, ref_ovf(v, 2));
    @(negedge clk);
  endtask

  task automatic run_w16(input logic [15:0] v);
    int          n;
    logic [63:0] rb;
    n = 0;
    w_in_valid = 1'b1;
    w_in_data  = v;
    while (!w_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    w_in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!w_out_valid && n < 50);
    rb = ref_bcd(v, D16);
    chk("w16_latency", n, 16);
    chk("w16_bcd", w_out_bcd, rb[19:0]);
    chk("w16_ovf", w_out_ovf, ref_ovf(v, D16));
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #22;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bcd", out_bcd, 12'h000);
    chk("rst_out_ovf", out_ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {in_ready, d2_in_ready, w_in_ready}, 3'b111);
    @(negedge clk);

    send(8'd255, 1'b0);
    drain();

    run_d2(8'd156);
    run_d2(8'd99);
    run_d2(8'd100);
    for (int i = 0; i < 4; i++) run_d2(8'($urandom_range(0, 255)));

    run_w16(16'd65535);
    run_w16(16'd10000);
    run_w16(16'd0);
    for (int i = 0; i < 4; i++) run_w16(16'($urandom));

    bp_en = 1'b1;
    for (int v = 0; v < 256; v++) send(8'(v), 1'b0);
    for (int i = 0; i < 30; i++) send(8'($urandom), 1'b0);
    drain();
    bp_en = 1'b0;
    @(negedge clk);

    send(8'd1, 1'b1);
    send(8'd251, 1'b1);
    send(8'd100, 1'b0);
    drain();

    // abort a conversion of 112 with an asynchronous reset
    in_valid = 1'b1;
    in_data  = 8'd112;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {in_ready, out_valid, out_ovf, out_bcd}, 15'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", in_ready, 1'b1);
    @(negedge clk);
    send(8'd45, 1'b0);
    drain();

    chk("result_count", got, sent);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
